// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Control FSM for an AES datapath with run-time key size (128/192/256) and
// direction. Sequences plaintext load, key load, key expansion handshake,
// the initial AddRoundKey, all cipher rounds and the ciphertext readout.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   start_write_n           active-low start of plaintext+key load (IDLE only)
//   start_read_n            active-low start of ciphertext readout (DONE only)
//   key_len, decrypt        key size / direction, latched at start
//   key_expand_done         expander handshake, looked at in KEY_EXPAND only
//   abort                   synchronous return to IDLE, highest priority
//   done, busy, err         status; err is a 1-cycle pulse on reserved key_len
//   dbg_state, dbg_round    current state code and completed-round count
//   matrix_in_sel, matrix_write_enable, mat_row_col, mat_read_write, mat_idx
//                           state-matrix control
//   key_we, key_word_idx    key word load strobe and index
//   key_expand_start        1-cycle pulse on entering KEY_EXPAND
//   round_key_idx           round key used by the ARK states (0 elsewhere)
//
// state      | meaning
// IDLE       | waiting for start_write_n
// PT_WRITE   | COLS cycles, plaintext columns written
// KEY_WRITE  | Nk cycles, key words written
// KEY_EXPAND | waiting for key_expand_done
// INIT_ARK   | round-0 AddRoundKey
// SUB        | (Inv)SubBytes
// SHIFT      | (Inv)ShiftRows, row-wise
// MIX        | (Inv)MixColumns, skipped in the last round
// ARK        | AddRoundKey of the current round
// DONE       | ciphertext ready, waiting for start_read_n
// CT_READ    | COLS cycles, ciphertext columns read
module aes_round_sequencer #(
    parameter int COLS    = 4,
    parameter int MAX_NK  = 8,
    parameter int ROUND_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_write_n,
    input  logic               start_read_n,
    input  logic [1:0]         key_len,
    input  logic               decrypt,
    input  logic               key_expand_done,
    input  logic               abort,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic [3:0]         dbg_state,
    output logic [ROUND_W-1:0] dbg_round,
    output logic [2:0]         matrix_in_sel,
    output logic               matrix_write_enable,
    output logic               mat_row_col,
    output logic               mat_read_write,
    output logic [1:0]         mat_idx,
    output logic               key_we,
    output logic [2:0]         key_word_idx,
    output logic               key_expand_start,
    output logic [ROUND_W-1:0] round_key_idx
);

    localparam int LEN_MAX = (MAX_NK > COLS) ? MAX_NK : COLS;
    localparam int TW      = $clog2(LEN_MAX);
    localparam logic [TW-1:0] COLS_LAST = TW'(COLS - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PT_WRITE   = 4'd1,
        S_KEY_WRITE  = 4'd2,
        S_KEY_EXPAND = 4'd3,
        S_INIT_ARK   = 4'd4,
        S_SUB        = 4'd5,
        S_SHIFT      = 4'd6,
        S_MIX        = 4'd7,
        S_ARK        = 4'd8,
        S_DONE       = 4'd9,
        S_CT_READ    = 4'd10
    } state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      tmr, tmr_nxt;
    logic [ROUND_W-1:0] round_q, round_nxt;
    logic [1:0]         kl_q, kl_nxt;
    logic               dec_q, dec_nxt;
    logic               err_q, err_nxt;
    logic               kes_q, kes_nxt;

    logic [TW-1:0]      nk_last;
    logic [ROUND_W-1:0] nr;
    logic [ROUND_W-1:0] cur_round;
    logic               tc;
    logic               last_round;
    logic               op;

    always_comb begin
        case (kl_q)
            2'd1:    begin nk_last = TW'(5); nr = ROUND_W'(12); end
            2'd2:    begin nk_last = TW'(7); nr = ROUND_W'(14); end
            default: begin nk_last = TW'(3); nr = ROUND_W'(10); end
        endcase
    end

    // round_q counts completed rounds, so the round being executed is one ahead
    assign cur_round  = round_q + ROUND_W'(1);
    assign last_round = (cur_round == nr);
    assign tc         = (tmr == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tmr     <= '0;
            round_q <= '0;
            kl_q    <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            kes_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            round_q <= round_nxt;
            kl_q    <= kl_nxt;
            dec_q   <= dec_nxt;
            err_q   <= err_nxt;
            kes_q   <= kes_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tc ? '0 : tmr - 1'b1;
        round_nxt = round_q;
        kl_nxt    = kl_q;
        dec_nxt   = dec_q;
        err_nxt   = 1'b0;
        kes_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!start_write_n) begin
                    if (key_len == 2'b11) begin
                        err_nxt = 1'b1;
                    end else begin
                        kl_nxt    = key_len;
                        dec_nxt   = decrypt;
                        round_nxt = '0;
                        state_nxt = S_PT_WRITE;
                        tmr_nxt   = COLS_LAST;
                    end
                end
            end
            S_PT_WRITE: if (tc) begin
                state_nxt = S_KEY_WRITE;
                tmr_nxt   = nk_last;
            end
            S_KEY_WRITE: if (tc) begin
                state_nxt = S_KEY_EXPAND;
                kes_nxt   = 1'b1;
            end
            S_KEY_EXPAND: if (key_expand_done) begin
                state_nxt = S_INIT_ARK;
                tmr_nxt   = COLS_LAST;
            end
            S_INIT_ARK: if (tc) begin
                state_nxt = dec_q ? S_SHIFT : S_SUB;
                tmr_nxt   = COLS_LAST;
            end
            S_SUB: if (tc) begin
                state_nxt = dec_q ? S_ARK : S_SHIFT;
                tmr_nxt   = COLS_LAST;
            end
            S_SHIFT: if (tc) begin
                if (dec_q)           state_nxt = S_SUB;
                else if (last_round) state_nxt = S_ARK;
                else                 state_nxt = S_MIX;
                tmr_nxt = COLS_LAST;
            end
            S_MIX: if (tc) begin
                // inverse cipher ends a non-final round with MIX
                if (dec_q) begin
                    round_nxt = cur_round;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_ARK;
                end
                tmr_nxt = COLS_LAST;
            end
            S_ARK: if (tc) begin
                if (dec_q && !last_round) begin
                    state_nxt = S_MIX;
                    tmr_nxt   = COLS_LAST;
                end else begin
                    round_nxt = cur_round;
                    if (last_round) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SUB;
                        tmr_nxt   = COLS_LAST;
                    end
                end
            end
            S_DONE: if (!start_read_n) begin
                state_nxt = S_CT_READ;
                tmr_nxt   = COLS_LAST;
            end
            S_CT_READ: if (tc) begin
                state_nxt = S_IDLE;
                round_nxt = '0;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
            round_nxt = '0;
            err_nxt   = 1'b0;
            kes_nxt   = 1'b0;
        end
    end

    always_comb begin
        done                = 1'b0;
        busy                = 1'b0;
        matrix_in_sel       = 3'd0;
        matrix_write_enable = 1'b0;
        mat_row_col         = 1'b0;
        mat_read_write      = 1'b0;
        mat_idx             = 2'd0;
        key_we              = 1'b0;
        key_word_idx        = 3'd0;
        round_key_idx       = '0;
        op                  = 1'b0;
        case (state)
            S_PT_WRITE: begin
                op            = 1'b1;
                matrix_in_sel = 3'd0;
            end
            S_KEY_WRITE: begin
                busy         = 1'b1;
                key_we       = 1'b1;
                key_word_idx = 3'(nk_last - tmr);
            end
            S_KEY_EXPAND: busy = 1'b1;
            S_INIT_ARK: begin
                op            = 1'b1;
                matrix_in_sel = 3'd4;
                round_key_idx = dec_q ? nr : '0;
            end
            S_SUB: begin
                op            = 1'b1;
                matrix_in_sel = dec_q ? 3'd5 : 3'd1;
            end
            S_SHIFT: begin
                op            = 1'b1;
                matrix_in_sel = dec_q ? 3'd6 : 3'd2;
            end
            S_MIX: begin
                op            = 1'b1;
                matrix_in_sel = dec_q ? 3'd7 : 3'd3;
            end
            S_ARK: begin
                op            = 1'b1;
                matrix_in_sel = 3'd4;
                round_key_idx = dec_q ? nr - cur_round : cur_round;
            end
            S_DONE: done = 1'b1;
            S_CT_READ: begin
                done        = 1'b1;
                busy        = 1'b1;
                mat_row_col = 1'b1;
                mat_idx     = 2'(COLS_LAST - tmr);
            end
            default: ;
        endcase
        // every matrix-writing state walks the columns (rows for SHIFT)
        if (op) begin
            busy                = 1'b1;
            matrix_write_enable = 1'b1;
            mat_read_write      = 1'b1;
            mat_row_col         = (state != S_SHIFT);
            mat_idx             = 2'(COLS_LAST - tmr);
        end
    end

    assign dbg_state        = state;
    assign dbg_round        = round_q;
    assign err              = err_q;
    assign key_expand_start = kes_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer: randomized runs compared cycle by cycle
// against an expected trace built from the cipher's round structure.
module tb_aes_round_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start_write_n;
    logic       start_read_n;
    logic [1:0] key_len;
    logic       decrypt;
    logic       key_expand_done;
    logic       abort;
    logic       done;
    logic       busy;
    logic       err;
    logic [3:0] dbg_state;
    logic [3:0] dbg_round;
    logic [2:0] matrix_in_sel;
    logic       matrix_write_enable;
    logic       mat_row_col;
    logic       mat_read_write;
    logic [1:0] mat_idx;
    logic       key_we;
    logic [2:0] key_word_idx;
    logic       key_expand_start;
    logic [3:0] round_key_idx;

    int n_cmp = 0;
    int n_mis = 0;
    logic [27:0] exp_q[$];
    int kx_idx;

    aes_round_sequencer dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start_write_n       (start_write_n),
        .start_read_n        (start_read_n),
        .key_len             (key_len),
        .decrypt             (decrypt),
        .key_expand_done     (key_expand_done),
        .abort               (abort),
        .done                (done),
        .busy                (busy),
        .err                 (err),
        .dbg_state           (dbg_state),
        .dbg_round           (dbg_round),
        .matrix_in_sel       (matrix_in_sel),
        .matrix_write_enable (matrix_write_enable),
        .mat_row_col         (mat_row_col),
        .mat_read_write      (mat_read_write),
        .mat_idx             (mat_idx),
        .key_we              (key_we),
        .key_word_idx        (key_word_idx),
        .key_expand_start    (key_expand_start),
        .round_key_idx       (round_key_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // one output snapshot: state,sel,rc,rw,we,round,rki,idx,kwe,kwidx,kes,busy,done,err
    function automatic logic [27:0] pk(int st, int sel, int rc, int rw, int we, int rnd,
                                       int rki, int idx, int kwe, int kwidx, int kes,
                                       int bsy, int dn, int er);
        return {st[3:0], sel[2:0], rc[0], rw[0], we[0], rnd[3:0], rki[3:0], idx[1:0],
                kwe[0], kwidx[2:0], kes[0], bsy[0], dn[0], er[0]};
    endfunction

    function automatic logic [27:0] obs();
        return pk(int'(dbg_state), int'(matrix_in_sel), int'(mat_row_col), int'(mat_read_write),
                  int'(matrix_write_enable), int'(dbg_round), int'(round_key_idx), int'(mat_idx),
                  int'(key_we), int'(key_word_idx), int'(key_expand_start), int'(busy),
                  int'(done), int'(err));
    endfunction

    task automatic push_op(input int st, input int sel, input int rc, input int rnd, input int rki);
        for (int i = 0; i < 4; i++) exp_q.push_back(pk(st, sel, rc, 1, 1, rnd, rki, i, 0, 0, 0, 1, 0, 0));
    endtask

    // expected trace from the first cycle after start up to the first DONE cycle
    task automatic build(input int kl, input int dec, input int d);
        int nk, nr;
        nk = 4 + 2 * kl;
        nr = 10 + 2 * kl;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(pk(1, 0, 1, 1, 1, 0, 0, i, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < nk; i++) exp_q.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 1, 0, 0));
        kx_idx = exp_q.size();
        for (int i = 0; i <= d; i++) exp_q.push_back(pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) ? 1 : 0, 1, 0, 0));
        push_op(4, 4, 1, 0, dec ? nr : 0);
        for (int r = 1; r <= nr; r++) begin
            if (!dec) begin
                push_op(5, 1, 1, r - 1, 0);
                push_op(6, 2, 0, r - 1, 0);
                if (r < nr) push_op(7, 3, 1, r - 1, 0);
                push_op(8, 4, 1, r - 1, r);
            end else begin
                push_op(6, 6, 0, r - 1, 0);
                push_op(5, 5, 1, r - 1, 0);
                push_op(8, 4, 1, r - 1, nr - r);
                if (r < nr) push_op(7, 7, 1, r - 1, 0);
            end
        end
        exp_q.push_back(pk(9, 0, 0, 0, 0, nr, 0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    function automatic int find_idx(input int st, input int rnd);
        logic [3:0] s4, r4;
        s4 = st[3:0];
        r4 = rnd[3:0];
        foreach (exp_q[i]) if (exp_q[i][27:24] == s4 && exp_q[i][17:14] == r4) return i;
        return -1;
    endfunction

    // mode 0: full run to DONE; 1: abort at (tst,trnd); 2: async reset at (tst,trnd)
    task automatic run(input int kl, input int dec, input int d, input int mode,
                       input int tst, input int trnd, output int done_cyc);
        int at;
        build(kl, dec, d);
        at = (mode != 0) ? find_idx(tst, trnd) : -1;
        done_cyc = -1;
        key_len = kl[1:0];
        decrypt = dec[0];
        key_expand_done = 1'($urandom);
        start_write_n = 1'b0;
        @(posedge clock); #1;
        start_write_n = 1'b1;
        for (int c = 0; c < exp_q.size(); c++) begin
            if (dbg_state == 4'd9 && done_cyc < 0) done_cyc = c;
            chk_val($sformatf("cyc%0d_kl%0d_dec%0d", c, kl, dec), obs(), exp_q[c]);
            if (c == exp_q.size() - 1) break;
            if (mode == 1 && c == at) begin
                abort = 1'b1;
                @(posedge clock); #1;
                abort = 1'b0;
                start_write_n = 1'b1;
                chk_val("abort_idle", obs(), 0);
                return;
            end
            if (mode == 2 && c == at) begin
                #1 reset_n = 1'b0;
                start_write_n = 1'b1;
                #1 chk_val("reset_mid", obs(), 0);
                #2 reset_n = 1'b1;
                @(posedge clock); #1;
                chk_val("reset_idle", obs(), 0);
                return;
            end
            if (c < kx_idx || c > kx_idx + d) key_expand_done = 1'($urandom);
            else key_expand_done = (c == kx_idx + d);
            // write starts while busy must be ignored
            start_write_n = ($urandom % 4) != 0;
            key_len = 2'($urandom);
            decrypt = 1'($urandom);
            @(posedge clock); #1;
        end
        start_write_n = 1'b1;
    endtask

    task automatic read_out(input int nr, input int with_write);
        start_write_n = 1'b0;
        @(posedge clock); #1;
        start_write_n = 1'b1;
        chk_val("done_hold", obs(), pk(9, 0, 0, 0, 0, nr, 0, 0, 0, 0, 0, 0, 1, 0));
        start_read_n = 1'b0;
        if (with_write != 0) start_write_n = 1'b0;
        @(posedge clock); #1;
        start_read_n = 1'b1;
        start_write_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("ct_read%0d", i), obs(), pk(10, 0, 1, 0, 0, nr, 0, i, 0, 0, 0, 1, 1, 0));
            @(posedge clock); #1;
        end
        chk_val("ct_idle", obs(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, kl, dec, d;
        reset_n = 1'b0;
        start_write_n = 1'b1;
        start_read_n = 1'b1;
        key_len = 2'd0;
        decrypt = 1'b0;
        key_expand_done = 1'b0;
        abort = 1'b0;
        #3 chk_val("reset", obs(), 0);
        #10 reset_n = 1'b1;
        @(posedge clock); #1;

        // AES-128 encrypt, expander done on entry
        run(0, 0, 0, 0, 0, 0, dc);
        chk_val("latency128", dc, 169);
        read_out(10, 0);

        // AES-256 decrypt with a slow expander, write+read together in DONE
        run(2, 1, 3, 0, 0, 0, dc);
        read_out(14, 1);

        // reserved key length
        key_len = 2'b11;
        start_write_n = 1'b0;
        @(posedge clock); #1;
        start_write_n = 1'b1;
        chk_val("err_pulse", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clock); #1;
        chk_val("err_clear", obs(), 0);

        // abort in round 5 SUB, then a full AES-192 run
        run(0, 0, 2, 1, 5, 4, dc);
        run(1, 0, 1, 0, 0, 0, dc);
        read_out(12, 0);

        // async reset in the middle of a MIX
        run(0, 1, 0, 2, 7, 2, dc);

        repeat (8) begin
            kl  = $urandom % 3;
            dec = $urandom % 2;
            d   = $urandom % 6;
            run(kl, dec, d, 0, 0, 0, dc);
            read_out(10 + 2 * kl, $urandom % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
